// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM state type, default widths and saturation bounds for the neuron datapath.
package nn_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 24;
    localparam int OUT_WIDTH  = 8;
    localparam int OUT_MAX    = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN    = -(1 << (OUT_WIDTH - 1));
endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/bias control, weight/activation input stream and neuron result output stream.
interface neuron_mac_if #(
    parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = nn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = nn_pkg::OUT_WIDTH,
    parameter int NUM_TAPS   = 16
);
    logic                            start;
    logic signed [ACC_WIDTH-1:0]     bias;
    logic                            in_valid;
    logic                            in_ready;
    logic signed [DATA_WIDTH-1:0]    weight;
    logic signed [DATA_WIDTH-1:0]    activation;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [OUT_WIDTH-1:0]     out_data;
    logic                            busy;
    logic [$clog2(NUM_TAPS+1)-1:0]   tap_count;
    modport master (output start, bias, in_valid, weight, activation, out_ready,
                    input in_ready, out_valid, out_data, busy, tap_count);
    modport slave  (input start, bias, in_valid, weight, activation, out_ready,
                    output in_ready, out_valid, out_data, busy, tap_count);
endinterface

// File: rtl/neuron_sat_shift.sv
// neuron_sat_shift: arithmetic shift, optional ReLU (NEURON_MAC_RELU_EN) and saturation to OUT_WIDTH.
module neuron_sat_shift #(
    parameter int ACC_WIDTH  = nn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = nn_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT = 0
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic signed [OUT_WIDTH-1:0] o_data
);
    localparam logic signed [ACC_WIDTH-1:0] L_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] L_MIN = ACC_WIDTH'(-(1 << (OUT_WIDTH - 1)));
    logic signed [ACC_WIDTH-1:0] w_sh;
    logic signed [ACC_WIDTH-1:0] w_r;
    assign w_sh = i_acc >>> FRAC_SHIFT;
`ifdef NEURON_MAC_RELU_EN
    assign w_r = w_sh[ACC_WIDTH-1] ? '0 : w_sh;
`else
    assign w_r = w_sh;
`endif
    assign o_data = (w_r > L_MAX) ? L_MAX[OUT_WIDTH-1:0] :
                    (w_r < L_MIN) ? L_MIN[OUT_WIDTH-1:0] : w_r[OUT_WIDTH-1:0];
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: one neuron dot product plus bias, scaled and saturated, over valid/ready streams.
// Build option: NEURON_MAC_RELU_EN clamps negative results to zero before saturation.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
    parameter int NUM_TAPS   = 16,
    parameter int ACC_WIDTH  = nn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = nn_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT = 0
) (
    input logic         clk,
    input logic         reset,
    neuron_mac_if.slave bus
);
    localparam int CW = $clog2(NUM_TAPS + 1);
    state_t                          r_state;
    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic [CW-1:0]                   r_cnt;
    logic signed [OUT_WIDTH-1:0]     r_out;
    logic signed [2*DATA_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]     w_sum;
    logic signed [OUT_WIDTH-1:0]     w_sat;
    logic                            w_beat;
    logic                            w_last;
    assign w_prod = bus.weight * bus.activation;
    assign w_sum  = r_acc + ACC_WIDTH'(w_prod);
    assign w_beat = (r_state == ACCUM) && bus.in_valid;
    assign w_last = r_cnt == CW'(NUM_TAPS - 1);
    neuron_sat_shift #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_SHIFT(FRAC_SHIFT)) u_sat (
        .i_acc  (w_sum),
        .o_data (w_sat)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_acc   <= bus.bias;
                    r_cnt   <= '0;
                    r_state <= ACCUM;
                end
                ACCUM: if (w_beat) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_sat;
                        r_state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = r_state == ACCUM;
    assign bus.out_valid = r_state == DONE;
    assign bus.busy      = r_state != IDLE;
    assign bus.out_data  = r_out;
    assign bus.tap_count = r_cnt;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vectors on a 4-tap neuron; u_a unshifted, u_b with FRAC_SHIFT=2 on the same stimulus.
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic signed [7:0] tw [4];
    logic signed [7:0] ta [4];
    int lat;
    int da;
    int db;
    always #5 clk = ~clk;
    neuron_mac_if #(.NUM_TAPS(4)) m_a ();
    neuron_mac_if #(.NUM_TAPS(4)) m_b ();
    assign m_b.start      = m_a.start;
    assign m_b.bias       = m_a.bias;
    assign m_b.in_valid   = m_a.in_valid;
    assign m_b.weight     = m_a.weight;
    assign m_b.activation = m_a.activation;
    assign m_b.out_ready  = m_a.out_ready;
    neuron_mac #(.NUM_TAPS(4), .FRAC_SHIFT(0)) u_a (.clk(clk), .reset(rst_n), .bus(m_a));
    neuron_mac #(.NUM_TAPS(4), .FRAC_SHIFT(2)) u_b (.clk(clk), .reset(rst_n), .bus(m_b));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int w0, w1, w2, w3, a0, a1, a2, a3);
        tw[0] = 8'(w0); tw[1] = 8'(w1); tw[2] = 8'(w2); tw[3] = 8'(w3);
        ta[0] = 8'(a0); ta[1] = 8'(a1); ta[2] = 8'(a2); ta[3] = 8'(a3);
    endtask

    task automatic run(input int bias, input bit gaps, input int hold, output int l, output int oa, output int ob);
        @(negedge clk);
        m_a.start = 1'b1;
        m_a.bias  = 24'(bias);
        @(negedge clk);
        m_a.start = 1'b0;
        l = 1;
        check("busy_rise", int'(m_a.busy), 1);
        check("ready_rise", int'(m_a.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                m_a.in_valid   = 1'b0;
                m_a.weight     = 8'($urandom);
                m_a.activation = 8'($urandom);
                @(negedge clk);
                l++;
                check("tap_gap", int'(m_a.tap_count), i);
            end
            m_a.in_valid   = 1'b1;
            m_a.weight     = tw[i];
            m_a.activation = ta[i];
            if (i == 3) check("early_valid", int'(m_a.out_valid), 0);
            @(negedge clk);
            l++;
            if (i < 3) check("tap_beat", int'(m_a.tap_count), i + 1);
        end
        m_a.in_valid = 1'b0;
        while (!m_a.out_valid && l < 30) begin
            @(negedge clk);
            l++;
        end
        check("valid", int'(m_a.out_valid), 1);
        oa = int'(m_a.out_data);
        ob = int'(m_b.out_data);
        for (int k = 0; k < hold; k++) begin
            m_a.start = 1'b1;
            m_a.in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", int'(m_a.out_valid), 1);
            check("hold_data", int'(m_a.out_data), oa);
            check("hold_ready", int'(m_a.in_ready), 0);
            check("hold_tap", int'(m_a.tap_count), 4);
        end
        m_a.in_valid  = 1'b0;
        m_a.start     = 1'b1;
        m_a.out_ready = 1'b1;
        @(negedge clk);
        m_a.start     = 1'b0;
        m_a.out_ready = 1'b0;
        check("valid_fall", int'(m_a.out_valid), 0);
        check("idle_busy", int'(m_a.busy), 0);
    endtask

    initial begin
        m_a.start = 1'b0; m_a.bias = '0; m_a.in_valid = 1'b0;
        m_a.weight = '0; m_a.activation = '0; m_a.out_ready = 1'b0;
        #12;
        check("rst_valid", int'(m_a.out_valid), 0);
        check("rst_busy", int'(m_a.busy), 0);
        check("rst_ready", int'(m_a.in_ready), 0);
        check("rst_data", int'(m_a.out_data), 0);
        rst_n = 1'b1;

        set_vec(1, 2, 3, 4, 10, 10, 10, 10);
        run(5, 1'b0, 0, lat, da, db);
        check("basic_lat", lat, 5);
        check("basic_a", da, 105);
        check("basic_b", db, 26);

        set_vec(-1, -1, -1, -1, 100, 100, 100, 100);
        run(0, 1'b0, 0, lat, da, db);
`ifdef NEURON_MAC_RELU_EN
        check("neg_a", da, 0);
        check("neg_b", db, 0);
`else
        check("neg_a", da, -128);
        check("neg_b", db, -100);
`endif

        set_vec(127, 127, 127, 127, 127, 127, 127, 127);
        run(0, 1'b0, 0, lat, da, db);
        check("possat_a", da, 127);
        check("possat_b", db, 127);

        set_vec(1, 2, 3, 4, 10, 10, 10, 10);
        run(5, 1'b1, 5, lat, da, db);
        check("gap_lat", lat, 9);
        check("gap_a", da, 105);

        @(negedge clk);
        m_a.start = 1'b1; m_a.bias = 24'(1000);
        @(negedge clk);
        m_a.start = 1'b0; m_a.in_valid = 1'b1; m_a.weight = 8'(50); m_a.activation = 8'(50);
        @(negedge clk);
        @(negedge clk);
        m_a.in_valid = 1'b0;
        check("mid_tap", int'(m_a.tap_count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(m_a.busy), 0);
        check("arst_ready", int'(m_a.in_ready), 0);
        check("arst_tap", int'(m_a.tap_count), 0);
        check("arst_valid", int'(m_a.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(m_a.busy), 0);
        run(5, 1'b0, 0, lat, da, db);
        check("fresh_a", da, 105);

        set_vec(1, -1, 2, -2, 5, 5, 3, 3);
        run(-7, 1'b0, 0, lat, da, db);
`ifdef NEURON_MAC_RELU_EN
        check("frac_a", da, 0);
        check("frac_b", db, 0);
`else
        check("frac_a", da, -7);
        check("frac_b", db, -2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
